// File: rtl/pll_freq_checker.sv
// PLL frequency checker: counts how far a Gray-coded PLL-domain counter
// advances over a fixed window of reference clocks and flags out-of-range results.
`timescale 1ns/1ps
module pll_freq_checker #(
  parameter int unsigned CNT_W      = 32,
  parameter int unsigned WIN_CYCLES = 1024,
  parameter int unsigned EXP_MIN    = 1000,
  parameter int unsigned EXP_MAX    = 1050
) (
  input  logic             clk,
  input  logic             i_reg_rst,
  input  logic [CNT_W-1:0] i_gray_cnt,
  input  logic             i_start,
  input  logic             i_continuous,
  input  logic             i_clear,
  output logic [CNT_W-1:0] o_delta,
  output logic             o_valid,
  output logic             o_pass,
  output logic             o_fail_sticky,
  output logic             o_busy,
  output logic [15:0]      o_meas_cnt
);

  localparam int unsigned WIN_W       = 16;
  localparam logic [WIN_W-1:0] WIN_LAST  = WIN_W'(WIN_CYCLES - 1);
  localparam logic [CNT_W-1:0] EXP_MIN_C = CNT_W'(EXP_MIN);
  localparam logic [CNT_W-1:0] EXP_MAX_C = CNT_W'(EXP_MAX);
  localparam logic [15:0]      MEAS_MAX  = 16'hFFFF;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ARM    = 2'd1,
    WINDOW = 2'd2,
    DONE   = 2'd3
  } state_e;

  state_e             state_q;
  logic [CNT_W-1:0]   sync1_q;
  logic [CNT_W-1:0]   sync2_q;
  logic [CNT_W-1:0]   bin_q;
  logic [CNT_W-1:0]   bin_d;
  logic [CNT_W-1:0]   start_q;
  logic [CNT_W-1:0]   end_q;
  logic [WIN_W-1:0]   win_cnt_q;
  logic [CNT_W-1:0]   delta_d;
  logic               pass_d;
  logic [CNT_W-1:0]   delta_q;
  logic               valid_q;
  logic               pass_q;
  logic               fail_sticky_q;
  logic               busy_q;
  logic [15:0]        meas_cnt_q;

  // Gray-to-binary: each binary bit is the XOR of all Gray bits at or above it
  always_comb begin
    bin_d = '0;
    bin_d[CNT_W-1] = sync2_q[CNT_W-1];
    for (int i = int'(CNT_W) - 2; i >= 0; i--) begin
      bin_d[i] = bin_d[i+1] ^ sync2_q[i];
    end
  end

  // Modular difference handles counter wrap; compare is unsigned
  always_comb begin
    delta_d = end_q - start_q;
    pass_d  = (delta_d >= EXP_MIN_C) && (delta_d <= EXP_MAX_C);
  end

  // Two-flop synchronizer followed by a registered decode
  always_ff @(posedge clk or posedge i_reg_rst) begin
    if (i_reg_rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
      bin_q   <= '0;
    end else begin
      sync1_q <= i_gray_cnt;
      sync2_q <= sync1_q;
      bin_q   <= bin_d;
    end
  end

  // Measurement FSM with registered result, status and statistics
  always_ff @(posedge clk or posedge i_reg_rst) begin
    if (i_reg_rst) begin
      state_q       <= IDLE;
      start_q       <= '0;
      end_q         <= '0;
      win_cnt_q     <= '0;
      delta_q       <= '0;
      valid_q       <= 1'b0;
      pass_q        <= 1'b0;
      fail_sticky_q <= 1'b0;
      busy_q        <= 1'b0;
      meas_cnt_q    <= '0;
    end else begin
      valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (i_start) begin
            state_q <= ARM;
            busy_q  <= 1'b1;
          end
        end
        ARM: begin
          start_q   <= bin_q;
          win_cnt_q <= '0;
          state_q   <= WINDOW;
        end
        WINDOW: begin
          if (win_cnt_q == WIN_LAST) begin
            end_q   <= bin_q;
            state_q <= DONE;
          end else begin
            win_cnt_q <= win_cnt_q + WIN_W'(1);
          end
        end
        DONE: begin
          delta_q <= delta_d;
          pass_q  <= pass_d;
          valid_q <= 1'b1;
          if (i_continuous) begin
            state_q <= ARM;
          end else begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase

      // A failing result beats a simultaneous clear
      if ((state_q == DONE) && !pass_d) begin
        fail_sticky_q <= 1'b1;
      end else if (i_clear) begin
        fail_sticky_q <= 1'b0;
      end

      // Clear together with a result leaves exactly that one result counted
      if (state_q == DONE) begin
        if (i_clear) begin
          meas_cnt_q <= 16'd1;
        end else if (meas_cnt_q != MEAS_MAX) begin
          meas_cnt_q <= meas_cnt_q + 16'd1;
        end
      end else if (i_clear) begin
        meas_cnt_q <= '0;
      end
    end
  end

  assign o_delta       = delta_q;
  assign o_valid       = valid_q;
  assign o_pass        = pass_q;
  assign o_fail_sticky = fail_sticky_q;
  assign o_busy        = busy_q;
  assign o_meas_cnt    = meas_cnt_q;

endmodule
